rx_frame_controller: RTL

RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

---
 rtl/rx_frame_controller.sv | 99 +++++++++
 1 files changed

// File: rtl/rx_frame_controller.sv
// rx_frame_controller: receives start/data/stop frames from a synchronized serial line,
// driving an external bit timer and reporting ready, overrun and framing status.
module rx_frame_controller #(
  parameter int MAX_DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     serial_in,
  input  logic [3:0]               data_size,
  input  logic                     shift_strobe,
  input  logic                     packet_done,
  input  logic                     data_read,
  output logic                     enable_timer,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     data_ready,
  output logic                     overrun_error,
  output logic                     framing_error
);
  localparam int W = MAX_DATA_BITS;
  typedef enum logic [1:0] {IDLE, RECEIVE, STOP_CHK} state_t;
  state_t         state_q, state_d;
  logic           sync1_q, sync1_d, sync_q, sync_d, prev_q, prev_d;
  logic           en_q, en_d, ready_q, ready_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic [3:0]     size_q, size_d, size_clamped;
  logic [W:0]     sh_q, sh_d;
  logic [W-1:0]   rx_q, rx_d;
  assign size_clamped = (data_size == 4'd0 || 32'(data_size) > W) ? 4'(W) : data_size;
  always_comb begin
    sync1_d = serial_in;
    sync_d  = sync1_q;
    prev_d  = sync_q;
    state_d = state_q;
    en_d    = en_q;
    size_d  = size_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    ready_d = data_read ? 1'b0 : ready_q;
    ovr_d   = data_read ? 1'b0 : ovr_q;
    ferr_d  = ferr_q;
    case (state_q)
      IDLE: if (prev_q && !sync_q) begin
        state_d = RECEIVE;
        en_d    = 1'b1;
        size_d  = size_clamped;
        ferr_d  = 1'b0;
        sh_d    = '1;
      end
      RECEIVE: begin
        sh_d    = shift_strobe ? {sync_q, sh_q[W:1]} : sh_q;
        state_d = packet_done ? STOP_CHK : RECEIVE;
        en_d    = !packet_done;
      end
      STOP_CHK: begin
        state_d = IDLE;
        if (sh_q[W]) begin
          // Unused low positions still hold the 1s preload; shifting drops them.
          rx_d    = sh_q[W-1:0] >> (W - 32'(size_q));
          ready_d = 1'b1;
          ovr_d   = ready_q && !data_read;
        end else begin
          ferr_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      en_q    <= 1'b0;
      size_q  <= 4'(W);
      sh_q    <= '1;
      rx_q    <= '0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      en_q    <= en_d;
      size_q  <= size_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end
  assign enable_timer  = en_q;
  assign rx_data       = rx_q;
  assign data_ready    = ready_q;
  assign overrun_error = ovr_q;
  assign framing_error = ferr_q;
endmodule
